// File: rtl/tone_decoder.sv
// tone_decoder
//   Decodes a speaker-style square wave into one of eight notes, C4 through C5.
//   The time between rising edges is measured in clk cycles and halved.
//   That half-period is matched against a fixed table within +/-TOL cycles.
//
// Parameters
//   TOL      max |measured half-period - table half-period| for a match
//   TIMEOUT  clk cycles without a rising edge before silence is declared
//
// Ports
//   clk       1 MHz system clock, rising edge
//   clr       asynchronous active-low reset
//   tone_in   asynchronous square wave to decode
//   key       one-hot note, bit0 = C4 ... bit7 = C5, zero when no note
//   valid     high while key holds a locked note
//   new_note  one-cycle pulse when key changes to a new nonzero value
//   m_out     last evaluated half-period in clk cycles
//
// Build option
//   TONE_DECODER_CONFIRM_EN  when defined, a new key is only accepted after two
//                            consecutive periods match the same note.
module tone_decoder #(
  parameter int TOL     = 8,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tone_in,
  output logic [7:0]  key,
  output logic        valid,
  output logic        new_note,
  output logic [15:0] m_out
);

  localparam logic [16:0] TOL_W     = 17'(TOL);
  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);
  localparam logic [16:0] CNT_MAX   = 17'h1FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCK    = 2'd2
  } state_t;

  // Half-period table in clk cycles at 1 MHz, C4 .. C5.
  function automatic logic [15:0] note_m(input logic [2:0] idx);
    case (idx)
      3'd0:    note_m = 16'd1911;
      3'd1:    note_m = 16'd1703;
      3'd2:    note_m = 16'd1517;
      3'd3:    note_m = 16'd1432;
      3'd4:    note_m = 16'd1276;
      3'd5:    note_m = 16'd1136;
      3'd6:    note_m = 16'd1012;
      3'd7:    note_m = 16'd956;
      default: note_m = 16'd0;
    endcase
  endfunction

  function automatic logic [16:0] abs_diff(input logic [16:0] a, input logic [16:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  logic        sync1_r;
  logic        sync2_r;
  logic        sync3_r;
  logic        edge_r;
  logic [16:0] cnt_r;
  state_t      state_r;

  logic [15:0] m_s;
  logic        match_hit_s;
  logic [2:0]  match_idx_s;
  logic [7:0]  match_key_s;
  logic        confirm_s;

  // The counter value just before reload is the full period; halve it by truncation.
  assign m_s         = cnt_r[16:1];
  assign match_key_s = 8'd1 << match_idx_s;

  // Synchroniser, registered rising-edge pulse and saturating period counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      edge_r  <= 1'b0;
      cnt_r   <= 17'd0;
    end else begin
      sync1_r <= tone_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      edge_r  <= sync2_r & ~sync3_r;
      if (edge_r) begin
        cnt_r <= 17'd1;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 17'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Table lookup: scanning from the top down lets the lowest matching note win.
  always_comb begin
    match_hit_s = 1'b0;
    match_idx_s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (abs_diff({1'b0, m_s}, {1'b0, note_m(3'(i))}) <= TOL_W) begin
        match_hit_s = 1'b1;
        match_idx_s = 3'(i);
      end else begin
        match_hit_s = match_hit_s;
      end
    end
    // A saturated counter means the period is unknown, never a note.
    if (cnt_r == CNT_MAX) begin
      match_hit_s = 1'b0;
    end else begin
      match_hit_s = match_hit_s;
    end
  end

`ifdef TONE_DECODER_CONFIRM_EN
  logic       prev_hit_r;
  logic [2:0] prev_idx_r;

  assign confirm_s = prev_hit_r && (prev_idx_r == match_idx_s);

  // Remembers the match result of the previous evaluated period.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prev_hit_r <= 1'b0;
      prev_idx_r <= 3'd0;
    end else if (edge_r) begin
      if (state_r != IDLE) begin
        prev_hit_r <= match_hit_s;
        prev_idx_r <= match_idx_s;
      end else begin
        prev_hit_r <= prev_hit_r;
        prev_idx_r <= prev_idx_r;
      end
    end else if (cnt_r == TIMEOUT_W) begin
      prev_hit_r <= 1'b0;
      prev_idx_r <= 3'd0;
    end else begin
      prev_hit_r <= prev_hit_r;
      prev_idx_r <= prev_idx_r;
    end
  end
`else
  assign confirm_s = 1'b1;
`endif

  // Note FSM with registered outputs; an edge outranks a coincident timeout.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r  <= IDLE;
      key      <= 8'd0;
      valid    <= 1'b0;
      new_note <= 1'b0;
      m_out    <= 16'd0;
    end else begin
      new_note <= 1'b0;
      if (edge_r) begin
        case (state_r)
          IDLE: begin
            // First edge only starts timing; there is no period yet.
            state_r <= MEASURE;
          end
          MEASURE: begin
            m_out <= m_s;
            if (match_hit_s && confirm_s) begin
              state_r  <= LOCK;
              key      <= match_key_s;
              valid    <= 1'b1;
              new_note <= 1'b1;
            end else begin
              state_r <= MEASURE;
            end
          end
          LOCK: begin
            m_out <= m_s;
            if (!match_hit_s) begin
              state_r <= MEASURE;
              key     <= 8'd0;
              valid   <= 1'b0;
            end else if ((match_key_s != key) && confirm_s) begin
              key      <= match_key_s;
              new_note <= 1'b1;
            end else begin
              state_r <= LOCK;
            end
          end
          default: begin
            state_r <= IDLE;
            key     <= 8'd0;
            valid   <= 1'b0;
          end
        endcase
      end else if (cnt_r == TIMEOUT_W) begin
        state_r <= IDLE;
        key     <= 8'd0;
        valid   <= 1'b0;
        m_out   <= 16'd0;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter TOL, default 8: max |measured m - table m| in clk cycles for a note match.
REQ-002 SHALL have parameter TIMEOUT, default 20000: clk cycles without a rising edge before silence is declared.
REQ-003 SHALL have port clk  input  1  system clock, 1 MHz, all logic on rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous active-low reset.
REQ-005 SHALL have port tone_in  input  1  asynchronous square wave (speaker-style signal) to decode.
REQ-006 SHALL have port key  output  8  one-hot decoded note, bit0=C4 ... bit7=C5; all zero when no note.
REQ-007 SHALL have port valid  output  1  high while key holds a locked note.
REQ-008 SHALL have port new_note  output  1  one-cycle pulse when key changes to a new nonzero value.
REQ-009 SHALL have port m_out  output  16  last measured half-period in clk cycles.

Function
REQ-010 SHALL synchronise tone_in through two flip-flops, then detect a rising edge with a third register; edge pulse is one cycle.
REQ-011 SHALL run a 17-bit period counter: loads 1 on edge, else increments, saturating at 0x1FFFF.
REQ-012 SHALL, on edge, capture period = counter value before reload, and m = period[16:1] (truncating).
REQ-013 SHALL use the fixed half-period table: k0 1911, k1 1703, k2 1517, k3 1432, k4 1276, k5 1136, k6 1012, k7 956.
REQ-014 SHALL match m to key k when |m - M_k| <= TOL, using unsigned 17-bit difference; the lowest matching k wins; no match yields key index none.
REQ-015 SHALL implement states IDLE, MEASURE, LOCK.
REQ-016 IDLE: first edge -> MEASURE; no captured period is evaluated.
REQ-017 MEASURE: edge with match k satisfying confirm rule (REQ-031/032) -> LOCK, key = one-hot k, valid = 1, new_note pulse; edge with no match -> stay MEASURE.
REQ-018 LOCK: edge with match equal to current k -> stay, no pulse; edge with match j != k meeting confirm rule -> key = one-hot j, new_note pulse; edge with no match -> MEASURE, key = 0, valid = 0.
REQ-019 Any state: counter reaching TIMEOUT without edge -> IDLE, key = 0, valid = 0, m_out = 0.
REQ-020 m_out SHALL update with m on every evaluated edge, including non-matching ones.
REQ-021 key, valid, new_note, m_out SHALL be registered and update on the clock edge after the edge pulse: 4 clk cycles after tone_in rises before synchroniser sampling.
REQ-022 Edge and timeout in the same cycle: edge takes priority, counter reloads.
REQ-023 Saturated counter (period >= 0x1FFFF) SHALL be treated as no match.

Reset
REQ-024 clr low SHALL asynchronously force key = 0, valid = 0, new_note = 0, m_out = 0, state IDLE, counter 0, synchroniser and edge registers 0.
REQ-025 Release of clr SHALL take effect at the next clk rising edge; reset mid-note discards any partial period.

Configuration
REQ-030 Macro TONE_DECODER_CONFIRM_EN SHALL select note confirmation.
REQ-031 With TONE_DECODER_CONFIRM_EN defined: a new key is accepted only when two consecutive captured periods match the same k; a single mismatched period in LOCK clears key as REQ-018.
REQ-032 Without it: a single matching period is sufficient; no previous-match register exists.

Verification
REQ-040 Reset, then 440 Hz wave (high 1136, low 1136 cycles) -> key = 0x20, valid = 1, new_note pulses once, m_out = 1136; with CONFIRM_EN lock on 3rd rising edge, without it on 2nd.
REQ-041 Locked A4, switch to 1012-cycle halves -> key = 0x40, one new_note pulse, valid never drops if each period matches (confirm delays switch by one period).
REQ-042 Half-period 1911+8 -> key = 0x01; 1911+9 (1920) -> no match, key = 0, state MEASURE, m_out = 1920.
REQ-043 Locked note, tone_in held low 20000 cycles -> key = 0, valid = 0, m_out = 0, state IDLE; next tone relocks normally.
REQ-044 clr pulsed low mid-period while locked -> all outputs 0 immediately, without waiting for clk; relock requires full sequence again.
REQ-045 Glitch: one 50-cycle high pulse inside a locked C5 wave -> two mismatched periods -> key = 0, then relock to 0x80.
